// File: rtl/fpu_pkg.sv
// Shared types for the FPU issue/hazard controller: pipeline depth,
// register index width, in-flight entry layout and issue FSM states.
package fpu_pkg;

  localparam int NSTAGE = 4;
  localparam int REG_W  = 5;

  typedef struct packed {
    logic             v;
    logic             wr;
    logic [REG_W-1:0] rd;
    logic [1:0]       lat;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_WAIT = 2'd1,
    RELEASE  = 2'd2
  } state_t;

  localparam entry_t BUBBLE = '0;

  // idx is the zero-based stage index (stage k -> k-1).
  function automatic logic fwd_ok(entry_t e, logic [1:0] idx);
    return e.v & e.wr & (idx >= e.lat);
  endfunction

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// Issue-side bundle between FPU decode (master) and the issue controller (slave).
// Handshake: an instruction is accepted at a rising edge iff issue_valid and issue_ready are both high in that cycle.
interface fpu_issue_ctrl_if;
  import fpu_pkg::*;

  logic             issue_valid;
  logic [REG_W-1:0] issue_rd;
  logic             issue_wr;
  logic [1:0]       issue_lat;
  logic             issue_div;
  logic [REG_W-1:0] issue_rsa;
  logic [REG_W-1:0] issue_rsb;
  logic             use_a;
  logic             use_b;
  logic             div_done;
  logic             flush;
  logic             issue_ready;
  logic [REG_W-1:0] rdi_buf_1;
  logic [REG_W-1:0] rdi_buf_2;
  logic [REG_W-1:0] rdi_buf_3;
  logic [REG_W-1:0] rdi_buf_4;
  logic             legal_1;
  logic             legal_2;
  logic             legal_3;
  logic             legal_4;
  logic             div_busy;
  state_t           dbg_state;

  modport master (
    output issue_valid, issue_rd, issue_wr, issue_lat, issue_div,
           issue_rsa, issue_rsb, use_a, use_b, div_done, flush,
    input  issue_ready, rdi_buf_1, rdi_buf_2, rdi_buf_3, rdi_buf_4,
           legal_1, legal_2, legal_3, legal_4, div_busy, dbg_state
  );

  modport slave (
    input  issue_valid, issue_rd, issue_wr, issue_lat, issue_div,
           issue_rsa, issue_rsb, use_a, use_b, div_done, flush,
    output issue_ready, rdi_buf_1, rdi_buf_2, rdi_buf_3, rdi_buf_4,
           legal_1, legal_2, legal_3, legal_4, div_busy, dbg_state
  );

endinterface

// File: rtl/fpu_hazard_chk.sv
// Read-after-write check for one source register against the in-flight entries.
// Index 0 is stage1 (youngest); the youngest matching writer decides.
module fpu_hazard_chk
  import fpu_pkg::*;
(
  input  logic [REG_W-1:0]        src_i,
  input  logic                    use_i,
  input  entry_t [NSTAGE-1:0]     ent_i,
  output logic                    pending_o
);

  logic hit;

  // Scan oldest to youngest so a younger match overrides an older one.
  always_comb begin
    hit = 1'b0;
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      if (ent_i[k].v && ent_i[k].wr && (ent_i[k].rd == src_i)) begin
        hit = (2'(k) < ent_i[k].lat);
      end
    end
    pending_o = hit & use_i;
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FPU issue controller: tracks in-flight destinations, stalls on unresolved
// RAW hazards and parks long-latency divides in stage1 until div_done.
module fpu_issue_ctrl
  import fpu_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  fpu_issue_ctrl_if.slave bus
);

  entry_t [NSTAGE-1:0] ent_q, ent_d;
  state_t              state_q, state_d;
  entry_t              new_ent;
  entry_t              released;
  logic                pending_a, pending_b;
  logic                accept;

  fpu_hazard_chk u_chk_a (
    .src_i     (bus.issue_rsa),
    .use_i     (bus.use_a),
    .ent_i     (ent_q),
    .pending_o (pending_a)
  );

  fpu_hazard_chk u_chk_b (
    .src_i     (bus.issue_rsb),
    .use_i     (bus.use_b),
    .ent_i     (ent_q),
    .pending_o (pending_b)
  );

  assign bus.issue_ready = !pending_a && !pending_b && (state_q == IDLE) && !bus.flush;
  assign accept          = bus.issue_valid && bus.issue_ready;

  always_comb begin
    state_d      = state_q;
    ent_d        = ent_q;
    new_ent.v    = 1'b1;
    new_ent.wr   = bus.issue_wr;
    new_ent.rd   = bus.issue_rd;
    // A parked divide must never look forwardable while it waits.
    new_ent.lat  = bus.issue_div ? 2'd3 : bus.issue_lat;
    released     = ent_q[0];
    released.lat = 2'd0;
    case (state_q)
      IDLE: begin
        ent_d = {ent_q[NSTAGE-2:0], BUBBLE};
        if (accept) begin
          ent_d[0] = new_ent;
          if (bus.issue_div) state_d = DIV_WAIT;
        end
      end
      DIV_WAIT: begin
        ent_d = {ent_q[NSTAGE-2:1], BUBBLE, ent_q[0]};
        if (bus.div_done) state_d = RELEASE;
      end
      RELEASE: begin
        ent_d   = {ent_q[NSTAGE-2:1], released, BUBBLE};
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.flush) begin
      ent_d   = '0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ent_q   <= '0;
      state_q <= IDLE;
    end else begin
      ent_q   <= ent_d;
      state_q <= state_d;
    end
  end

  assign bus.rdi_buf_1 = ent_q[0].v ? ent_q[0].rd : '0;
  assign bus.rdi_buf_2 = ent_q[1].v ? ent_q[1].rd : '0;
  assign bus.rdi_buf_3 = ent_q[2].v ? ent_q[2].rd : '0;
  assign bus.rdi_buf_4 = ent_q[3].v ? ent_q[3].rd : '0;
  assign bus.legal_1   = fwd_ok(ent_q[0], 2'd0);
  assign bus.legal_2   = fwd_ok(ent_q[1], 2'd1);
  assign bus.legal_3   = fwd_ok(ent_q[2], 2'd2);
  assign bus.legal_4   = fwd_ok(ent_q[3], 2'd3);
  assign bus.div_busy  = (state_q != IDLE);
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: RAW stalls, WAW masking, divide hold slot,
// flush and asynchronous reset, with hand-computed expectations.
module tb_fpu_issue_ctrl;
  import fpu_pkg::*;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_pass;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  fpu_issue_ctrl_if bus ();

  fpu_issue_ctrl dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] legal_vec();
    return {bus.legal_4, bus.legal_3, bus.legal_2, bus.legal_1};
  endfunction

  function automatic logic [19:0] rdi_vec();
    return {bus.rdi_buf_4, bus.rdi_buf_3, bus.rdi_buf_2, bus.rdi_buf_1};
  endfunction

  // driver tasks
  task automatic idle_in();
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;
    bus.issue_wr    = 1'b0;
    bus.issue_lat   = '0;
    bus.issue_div   = 1'b0;
    bus.issue_rsa   = '0;
    bus.issue_rsb   = '0;
    bus.use_a       = 1'b0;
    bus.use_b       = 1'b0;
    bus.div_done    = 1'b0;
    bus.flush       = 1'b0;
  endtask

  task automatic set_issue(input logic [4:0] rd, input logic [1:0] lat, input logic div,
                           input logic [4:0] rsa, input logic ua,
                           input logic [4:0] rsb, input logic ub);
    idle_in();
    bus.issue_valid = 1'b1;
    bus.issue_rd    = rd;
    bus.issue_wr    = 1'b1;
    bus.issue_lat   = lat;
    bus.issue_div   = div;
    bus.issue_rsa   = rsa;
    bus.use_a       = ua;
    bus.issue_rsb   = rsb;
    bus.use_b       = ub;
  endtask

  task automatic drain();
    repeat (5) begin
      @(negedge clk);
      idle_in();
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rstn     = 1'b0;
    idle_in();
    repeat (2) @(negedge clk);
    #1;
    check("rst_legal", 32'(legal_vec()), 32'h0);
    check("rst_rdi", 32'(rdi_vec()), 32'h0);
    check("rst_ready", 32'(bus.issue_ready), 32'd1);
    check("rst_busy", 32'(bus.div_busy), 32'd0);
    rstn = 1'b1;

    // RAW stall on a lat=2 producer
    @(negedge clk);
    set_issue(5'd5, 2'd2, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    #1 check("a_prod_ready", 32'(bus.issue_ready), 32'd1);
    @(negedge clk);
    set_issue(5'd10, 2'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
    exp_q = '{32'd0, 32'd0, 32'd1};
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      exp_v = exp_q.pop_front();
      check("a_stall_ready", 32'(bus.issue_ready), exp_v);
    end
    check("a_legal3", 32'(bus.legal_3), 32'd1);
    check("a_rdi3", 32'(bus.rdi_buf_3), 32'd5);
    @(negedge clk);
    idle_in();
    #1 check("a_cons_rdi1", 32'(bus.rdi_buf_1), 32'd10);
    drain();

    // lat=0 producer allows back-to-back
    @(negedge clk);
    set_issue(5'd7, 2'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    #1 check("b_prod_ready", 32'(bus.issue_ready), 32'd1);
    @(negedge clk);
    set_issue(5'd8, 2'd1, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
    #1;
    check("b_cons_ready", 32'(bus.issue_ready), 32'd1);
    check("b_legal1", 32'(bus.legal_1), 32'd1);
    check("b_rdi1", 32'(bus.rdi_buf_1), 32'd7);
    @(negedge clk);
    idle_in();
    #1;
    check("b_legal_vec", 32'(legal_vec()), 32'h2);
    check("b_rdi_vec", 32'(rdi_vec()), {12'h0, 20'h0_00_E8});
    drain();

    // WAW: younger non-forwardable writer masks older legal one
    @(negedge clk);
    set_issue(5'd3, 2'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    set_issue(5'd3, 2'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    #1 check("c_old_legal1", 32'(bus.legal_1), 32'd1);
    @(negedge clk);
    set_issue(5'd12, 2'd0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0);
    #1 check("c_old_legal2", 32'(bus.legal_2), 32'd1);
    exp_q = '{32'd0, 32'd0, 32'd0, 32'd1};
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      exp_v = exp_q.pop_front();
      check("c_waw_ready", 32'(bus.issue_ready), exp_v);
    end
    check("c_legal4", 32'(bus.legal_4), 32'd1);
    check("c_rdi4", 32'(bus.rdi_buf_4), 32'd3);
    drain();

    // divide in the hold slot with an older entry draining
    @(negedge clk);
    set_issue(5'd2, 2'd1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    set_issue(5'd9, 2'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1 check("d_div_ready", 32'(bus.issue_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      idle_in();
      if (i == 2) set_issue(5'd20, 2'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      if (i == 5) bus.div_done = 1'b1;
      #1;
      check("d_busy", 32'(bus.div_busy), 32'd1);
      if (i == 0) begin
        check("d_state", 32'(bus.dbg_state), 32'(DIV_WAIT));
        check("d_rdi_vec0", 32'(rdi_vec()), {12'h0, 5'd0, 5'd0, 5'd2, 5'd9});
        check("d_legal_vec0", 32'(legal_vec()), 32'h2);
      end
      if (i == 1) check("d_rdi_vec1", 32'(rdi_vec()), {12'h0, 5'd0, 5'd2, 5'd0, 5'd9});
      if (i == 2) check("d_hold_ready", 32'(bus.issue_ready), 32'd0);
      if (i == 3) check("d_rdi_vec3", 32'(rdi_vec()), {12'h0, 5'd0, 5'd0, 5'd0, 5'd9});
    end
    @(negedge clk);
    idle_in();
    #1;
    check("d_release_busy", 32'(bus.div_busy), 32'd1);
    check("d_release_rdi1", 32'(bus.rdi_buf_1), 32'd9);
    @(negedge clk);
    #1;
    check("d_after_busy", 32'(bus.div_busy), 32'd0);
    check("d_after_rdi_vec", 32'(rdi_vec()), {12'h0, 5'd0, 5'd0, 5'd9, 5'd0});
    check("d_after_legal_vec", 32'(legal_vec()), 32'h2);
    check("d_after_ready", 32'(bus.issue_ready), 32'd1);
    drain();

    // flush beats a same-cycle issue while a divide is parked
    @(negedge clk);
    set_issue(5'd11, 2'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    set_issue(5'd4, 2'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    set_issue(5'd6, 2'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    bus.flush = 1'b1;
    #1;
    check("e_flush_ready", 32'(bus.issue_ready), 32'd0);
    check("e_pre_busy", 32'(bus.div_busy), 32'd1);
    @(negedge clk);
    idle_in();
    #1;
    check("e_legal_vec", 32'(legal_vec()), 32'h0);
    check("e_rdi_vec", 32'(rdi_vec()), 32'h0);
    check("e_busy", 32'(bus.div_busy), 32'd0);
    check("e_ready", 32'(bus.issue_ready), 32'd1);
    drain();

    // asynchronous reset with three live entries
    @(negedge clk);
    set_issue(5'd13, 2'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    set_issue(5'd14, 2'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    set_issue(5'd15, 2'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    idle_in();
    #1 check("f_pre_legal_vec", 32'(legal_vec()), 32'h7);
    #1 rstn = 1'b0;
    #1;
    check("f_rst_legal_vec", 32'(legal_vec()), 32'h0);
    check("f_rst_rdi_vec", 32'(rdi_vec()), 32'h0);
    check("f_rst_ready", 32'(bus.issue_ready), 32'd1);
    check("f_rst_busy", 32'(bus.div_busy), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
